// File: rtl/dispatch_ctrl_pkg.sv
// dispatch_ctrl_pkg: opcode constants, dispatch state encoding and the load/store classifier
package dispatch_ctrl_pkg;
  localparam int PC_LEN = 32;
  localparam int INSTR_LEN = 32;
  localparam int OP_LEN = 6;
  localparam logic [OP_LEN-1:0] OP_NOP  = 6'd0;
  localparam logic [OP_LEN-1:0] OP_LB   = 6'd11;
  localparam logic [OP_LEN-1:0] OP_LH   = 6'd12;
  localparam logic [OP_LEN-1:0] OP_LW   = 6'd13;
  localparam logic [OP_LEN-1:0] OP_LBU  = 6'd14;
  localparam logic [OP_LEN-1:0] OP_LHU  = 6'd15;
  localparam logic [OP_LEN-1:0] OP_SB   = 6'd16;
  localparam logic [OP_LEN-1:0] OP_SH   = 6'd17;
  localparam logic [OP_LEN-1:0] OP_SW   = 6'd18;
  localparam logic [OP_LEN-1:0] OP_ADDI = 6'd19;
  typedef enum logic {DISP_IDLE = 1'b0, DISP_HOLD = 1'b1} disp_state_e;
  function automatic logic is_ls(input logic [OP_LEN-1:0] op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
  endfunction
endpackage

// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: holds one instruction for the decoder and issues it to LSB or RS with a ROB allocation
module dispatch_ctrl
  import dispatch_ctrl_pkg::*;
#(
  parameter int PC_W = PC_LEN,
  parameter int INSTR_W = INSTR_LEN,
  parameter int OP_W = OP_LEN,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_from_rob,
  input  logic               is_empty_from_instr_queue,
  input  logic [INSTR_W-1:0] instr_from_instr_queue,
  input  logic [PC_W-1:0]    pc_from_instr_queue,
  output logic               pop_to_instr_queue,
  output logic [INSTR_W-1:0] instr_to_dc,
  output logic [PC_W-1:0]    pc_to_dc,
  input  logic [OP_W-1:0]    op_from_dc,
  input  logic               rob_full,
  input  logic               rs_full,
  input  logic               lsb_full,
  output logic               rob_alloc,
  output logic               rs_issue,
  output logic               lsb_issue,
  output logic               busy,
  output logic [CNT_W-1:0]   stall_cnt
);
  disp_state_e state, state_nxt;
  logic ls_op, tgt_full, fire, pop;
  always_comb begin
    ls_op = is_ls(op_from_dc);
    tgt_full = ls_op ? lsb_full : rs_full;
    // rst gating keeps every combinational output low while reset is held
    fire = rst && state == DISP_HOLD && !flush_from_rob && !rob_full && !tgt_full;
    pop = rst && !is_empty_from_instr_queue && !flush_from_rob && (state == DISP_IDLE || fire);
    state_nxt = flush_from_rob ? DISP_IDLE : pop ? DISP_HOLD : fire ? DISP_IDLE : state;
  end
  assign pop_to_instr_queue = pop;
  assign rob_alloc = fire;
  assign rs_issue = fire && !ls_op;
  assign lsb_issue = fire && ls_op;
  assign busy = state == DISP_HOLD;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= DISP_IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      instr_to_dc <= '0;
      pc_to_dc <= '0;
      stall_cnt <= '0;
    end else begin
      if (pop) begin
        instr_to_dc <= instr_from_instr_queue;
        pc_to_dc <= pc_from_instr_queue;
      end
      if (state == DISP_HOLD && !fire && !flush_from_rob && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
    end
endmodule

// File: tb/tb_dispatch_ctrl.sv
// tb_dispatch_ctrl: scoreboarded sequences plus a classification vector table for dispatch_ctrl
module tb_dispatch_ctrl;
  import dispatch_ctrl_pkg::*;
  localparam logic [31:0] I_ADDI = 32'h00A00093;
  localparam logic [31:0] I_LW   = 32'h0000A103;
  localparam logic [31:0] I_SW   = 32'h0020A223;
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        ls;
  } exp_t;
  typedef struct {
    logic [5:0] op;
    logic       rob_f;
    logic       rs_f;
    logic       lsb_f;
    logic       fl;
    logic [3:0] exp;
  } vec_t;
  logic clk = 0, rst = 0, flush = 0, empty = 1, rob_full = 0, rs_full = 0, lsb_full = 0;
  logic [31:0] instr_q = '0, pc_q = '0;
  logic pop, rob_alloc, rs_issue, lsb_issue, busy;
  logic [31:0] instr_to_dc, pc_to_dc;
  logic [3:0] stall_cnt;
  logic [5:0] op_from_dc, op_ovr = '0;
  logic ovr_en = 0;
  int nerr = 0, nchk = 0;
  ent_t iq[$];
  exp_t sb[$];
  vec_t vt[$];
  always #5 clk = ~clk;
  function automatic logic [5:0] dc(input logic [31:0] i);
    logic [2:0] f3;
    f3 = i[14:12];
    if (i[6:0] == 7'b0000011)
      return f3 == 3'd0 ? OP_LB : f3 == 3'd1 ? OP_LH : f3 == 3'd2 ? OP_LW :
             f3 == 3'd4 ? OP_LBU : f3 == 3'd5 ? OP_LHU : OP_NOP;
    if (i[6:0] == 7'b0100011)
      return f3 == 3'd0 ? OP_SB : f3 == 3'd1 ? OP_SH : f3 == 3'd2 ? OP_SW : OP_NOP;
    if (i[6:0] == 7'b0010011) return OP_ADDI;
    return OP_NOP;
  endfunction
  assign op_from_dc = ovr_en ? op_ovr : dc(instr_to_dc);
  dispatch_ctrl #(.PC_W(32), .INSTR_W(32), .OP_W(6), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .flush_from_rob(flush),
    .is_empty_from_instr_queue(empty), .instr_from_instr_queue(instr_q), .pc_from_instr_queue(pc_q),
    .pop_to_instr_queue(pop), .instr_to_dc(instr_to_dc), .pc_to_dc(pc_to_dc), .op_from_dc(op_from_dc),
    .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
    .rob_alloc(rob_alloc), .rs_issue(rs_issue), .lsb_issue(lsb_issue), .busy(busy), .stall_cnt(stall_cnt)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive_q();
    empty = iq.size() == 0;
    instr_q = iq.size() != 0 ? iq[0].instr : '0;
    pc_q = iq.size() != 0 ? iq[0].pc : '0;
  endtask
  task automatic push(input logic [31:0] i, input logic [31:0] p, input logic ls);
    iq.push_back('{i, p});
    sb.push_back('{i, p, ls});
    drive_q();
  endtask
  task automatic sb_check();
    exp_t e;
    if (rob_alloc !== 1'b1) return;
    if (sb.size() == 0) begin
      chk("sb_unexpected_issue", 32'(rob_alloc), 32'd0);
      return;
    end
    e = sb.pop_front();
    chk("sb_instr", instr_to_dc, e.instr);
    chk("sb_pc", pc_to_dc, e.pc);
    chk("sb_kind", {30'd0, lsb_issue, rs_issue}, e.ls ? 32'd2 : 32'd1);
  endtask
  task automatic tick();
    logic p;
    #1;
    sb_check();
    p = pop;
    @(posedge clk);
    #1;
    if (p && iq.size() != 0) iq.delete(0);
    drive_q();
  endtask
  function automatic vec_t mk(input logic [5:0] op, input logic rf, input logic sf, input logic lf,
                              input logic fl, input logic [3:0] exp);
    vec_t v;
    v.op = op; v.rob_f = rf; v.rs_f = sf; v.lsb_f = lf; v.fl = fl; v.exp = exp;
    return v;
  endfunction
  initial begin
    push(I_ADDI, 32'h0, 1'b0);
    push(I_LW, 32'h4, 1'b1);
    push(I_SW, 32'h8, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pop", 32'(pop), 0);
    chk("rst_outs", {29'd0, rob_alloc, rs_issue, lsb_issue}, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_instr", instr_to_dc, 0);
    chk("rst_pc", pc_to_dc, 0);
    chk("rst_stall", 32'(stall_cnt), 0);
    rst = 1;
    #1;
    chk("rel_pop", 32'(pop), 1);
    tick();
    chk("lat_instr", instr_to_dc, I_ADDI);
    chk("lat_pc", pc_to_dc, 32'h0);
    chk("lat_busy", 32'(busy), 1);
    #1;
    chk("b2b_rs", {29'd0, rob_alloc, rs_issue, lsb_issue}, 3'b110);
    tick();
    #1;
    chk("b2b_lsb1", {29'd0, rob_alloc, rs_issue, lsb_issue}, 3'b101);
    tick();
    #1;
    chk("b2b_lsb2", {29'd0, rob_alloc, rs_issue, lsb_issue}, 3'b101);
    chk("b2b_nopop", 32'(pop), 0);
    tick();
    chk("b2b_idle", {30'd0, busy, rob_alloc}, 0);
    lsb_full = 1;
    push(I_LW, 32'hC, 1'b1);
    tick();
    push(I_ADDI, 32'h10, 1'b0);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_noissue", {28'd0, pop, rob_alloc, rs_issue, lsb_issue}, 0);
      tick();
    end
    chk("stall_cnt5", 32'(stall_cnt), 5);
    lsb_full = 0;
    #1;
    chk("stall_release", {28'd0, pop, rob_alloc, rs_issue, lsb_issue}, 4'b1101);
    tick();
    rob_full = 1;
    repeat (2) begin
      #1;
      chk("robfull_block", {29'd0, rob_alloc, rs_issue, lsb_issue}, 0);
      tick();
    end
    rob_full = 0;
    #1;
    chk("robfull_release", {29'd0, rob_alloc, rs_issue, lsb_issue}, 3'b110);
    tick();
    #1;
    chk("robfull_single", {30'd0, busy, rob_alloc}, 0);
    chk("stall_cnt7", 32'(stall_cnt), 7);
    push(I_ADDI, 32'h14, 1'b0);
    push(I_LW, 32'h18, 1'b1);
    tick();
    flush = 1;
    #1;
    chk("flush_block", {28'd0, pop, rob_alloc, rs_issue, lsb_issue}, 0);
    sb.delete(0);
    tick();
    flush = 0;
    #1;
    chk("flush_busy", 32'(busy), 0);
    chk("flush_resume_pop", 32'(pop), 1);
    chk("flush_keeps_stall", 32'(stall_cnt), 7);
    tick();
    tick();
    chk("flush_drained", 32'(busy), 0);
    lsb_full = 1;
    push(I_SW, 32'h1C, 1'b1);
    tick();
    repeat (20) tick();
    chk("sat_15", 32'(stall_cnt), 15);
    tick();
    chk("sat_hold", 32'(stall_cnt), 15);
    chk("sat_busy", 32'(busy), 1);
    lsb_full = 0;
    #1;
    chk("pre_rst_fire", 32'(lsb_issue), 1);
    rst = 0;
    #1;
    chk("midrst_outs", {29'd0, rob_alloc, rs_issue, lsb_issue}, 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_stall", 32'(stall_cnt), 0);
    sb.delete(0);
    rst = 1;
    tick();
    chk("postrst_idle", {30'd0, busy, rob_alloc}, 0);
    chk("sb_drained", sb.size(), 0);
    iq.push_back('{I_ADDI, 32'h40});
    iq.push_back('{I_ADDI, 32'h44});
    drive_q();
    tick();
    vt.push_back(mk(OP_ADDI, 0, 0, 0, 0, 4'b1101));
    vt.push_back(mk(OP_ADDI, 0, 1, 0, 0, 4'b0000));
    vt.push_back(mk(OP_ADDI, 0, 0, 1, 0, 4'b1101));
    vt.push_back(mk(OP_ADDI, 1, 0, 0, 0, 4'b0000));
    vt.push_back(mk(OP_LW,   0, 0, 0, 0, 4'b1011));
    vt.push_back(mk(OP_LW,   0, 0, 1, 0, 4'b0000));
    vt.push_back(mk(OP_LW,   0, 1, 0, 0, 4'b1011));
    vt.push_back(mk(OP_LB,   0, 0, 0, 0, 4'b1011));
    vt.push_back(mk(OP_LH,   0, 0, 0, 0, 4'b1011));
    vt.push_back(mk(OP_LBU,  0, 0, 0, 0, 4'b1011));
    vt.push_back(mk(OP_LHU,  0, 0, 0, 0, 4'b1011));
    vt.push_back(mk(OP_SB,   0, 0, 0, 0, 4'b1011));
    vt.push_back(mk(OP_SH,   0, 0, 0, 0, 4'b1011));
    vt.push_back(mk(OP_SW,   0, 0, 0, 0, 4'b1011));
    vt.push_back(mk(OP_SW,   1, 0, 0, 0, 4'b0000));
    vt.push_back(mk(6'd63,   0, 0, 0, 0, 4'b1101));
    vt.push_back(mk(6'd63,   0, 1, 0, 0, 4'b0000));
    vt.push_back(mk(OP_ADDI, 0, 0, 0, 1, 4'b0000));
    vt.push_back(mk(OP_LW,   0, 0, 0, 1, 4'b0000));
    ovr_en = 1;
    foreach (vt[k]) begin
      op_ovr = vt[k].op;
      rob_full = vt[k].rob_f;
      rs_full = vt[k].rs_f;
      lsb_full = vt[k].lsb_f;
      flush = vt[k].fl;
      #1;
      chk($sformatf("vec%0d", k), {28'd0, rob_alloc, rs_issue, lsb_issue, pop}, 32'(vt[k].exp));
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end
endmodule

// File: doc/dispatch_ctrl.md
Name: dispatch_ctrl

Overview:
Sequences instruction flow from the instruction queue through the combinational decoder (dc) into the out-of-order back end.
- Holds one instruction in a register that drives dc.
- Classifies dc's decoded op as load/store or ALU/branch.
- Issues to the LSB or RS, plus a ROB allocation, only when the downstream resources have space.
- Drops in-flight work on a ROB flush.
- Sits between instr_queue and dc/rs/lsb/rob in the CPU top.

Parameters:
PC_W, 32, width of the pc path (`PcLength+1`).
INSTR_W, 32, instruction width (`InstrLength+1`).
OP_W, 6, decoded opcode width (`OpcodeLength+1`).
CNT_W, 16, stall counter width.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
flush_from_rob  in  1  mispredict/flush, level, sampled each cycle
is_empty_from_instr_queue  in  1  queue has no entry
instr_from_instr_queue  in  INSTR_W  head instruction
pc_from_instr_queue  in  PC_W  head pc
pop_to_instr_queue  out  1  combinational; queue advances head on this cycle's edge
instr_to_dc  out  INSTR_W  registered instruction to decoder
pc_to_dc  out  PC_W  registered pc to decoder
op_from_dc  in  OP_W  decoder's op for instr_to_dc
rob_full  in  1  ROB cannot accept
rs_full  in  1  RS cannot accept
lsb_full  in  1  LSB cannot accept
rob_alloc  out  1  combinational one-cycle allocate pulse
rs_issue  out  1  combinational one-cycle issue to RS
lsb_issue  out  1  combinational one-cycle issue to LSB
busy  out  1  registered; instruction held (state HOLD)
stall_cnt  out  CNT_W  registered saturating count of stalled HOLD cycles

Behaviour:
- States: IDLE (nothing held), HOLD (instr_to_dc valid).
- Reset (rst=0, async):
  - state=IDLE; instr_to_dc=0, pc_to_dc=0, busy=0, stall_cnt=0.
  - All combinational outputs evaluate to 0 while in reset.
- Definitions:
  - is_ls = op_from_dc ∈ {LB,LH,LW,LBU,LHU,SB,SH,SW}.
  - tgt_full = is_ls ? lsb_full : rs_full.
  - fire = (state==HOLD) & !flush_from_rob & !rob_full & !tgt_full.
- Outputs:
  - rob_alloc = fire.
  - rs_issue = fire & !is_ls.
  - lsb_issue = fire & is_ls.
  - Exactly one of rs_issue/lsb_issue accompanies each rob_alloc.
  - pop_to_instr_queue = !is_empty_from_instr_queue & !flush_from_rob & ((state==IDLE) | fire).
- Transitions at posedge clk:
  - flush_from_rob=1: state→IDLE, busy→0. instr_to_dc/pc_to_dc keep their old value (don't-care while IDLE). No pop, no issue. Flush has priority over everything.
  - IDLE & pop: latch instr/pc → HOLD. Latency queue-head → dc inputs = 1 cycle; first issue possible in the next cycle.
  - HOLD & fire & pop: latch next instr/pc, stay HOLD. Back-to-back throughput is 1 instruction/cycle.
  - HOLD & fire & !pop: → IDLE.
  - HOLD & !fire & !flush: hold all registers; stall_cnt += 1, saturating at 2^CNT_W−1.
  - IDLE & queue empty: stay IDLE; stall_cnt unchanged.
- Boundary conditions:
  - Resource-full deasserting in the same cycle a new instruction is latched has no effect on that instruction; it cannot fire until HOLD.
  - rob_full with tgt not full: no issue (both ROB and target are required).
  - Reset mid-HOLD: the held instruction is discarded; nothing is issued.
  - stall_cnt is cleared only by reset; flush does not clear it.
- Unknown opcode (dc default branch) is treated as non-LS and goes to RS. The ROB handles the illegal op.

Decomposition:
- Shared package (parameters.v extension):
  - opcode constants (already `LB`… `SW`);
  - function/macro IS_LS(op);
  - state encodings DISP_IDLE=1'b0, DISP_HOLD=1'b1;
  - width macros reused.
- No sub-module needed. dc is instantiated beside it in the CPU top, not inside it.

Test Plan:
1. Reset: hold rst=0 with queue non-empty → all outputs 0, no pop. Release → pop=1 in the first cycle; instr_to_dc=0x00A00093 (addi x1,x0,10), pc_to_dc=0x0 the next cycle.
2. Back-to-back: queue holds addi/0x0, lw 0x0000A103/0x4, sw 0x0020A223/0x8, all full=0.
   - Expected: rs_issue, lsb_issue, lsb_issue on 3 consecutive cycles, rob_alloc every cycle.
   - Then → IDLE, busy=0.
3. Stall: lw held, lsb_full=1 for 5 cycles, rs_full=0 → no issue, no pop, stall_cnt=5. lsb_full→0 → lsb_issue=1 that cycle.
4. ROB full: addi held, rob_full=1, rs_full=0 → rob_alloc=rs_issue=0. After release → single rob_alloc+rs_issue.
5. Flush: HOLD with fire conditions true, flush_from_rob=1 → no issue, no pop, next state IDLE, busy=0. Following cycle: pop resumes if queue non-empty.
6. Saturation: CNT_W=4, force 20 stall cycles → stall_cnt=15, stays 15.
